// File: rtl/dtree_pkg.sv
// Decision-tree types, sizes and the constant node table walked by dtree_seq_ctrl.
// Optional feature macro: DTREE_PREC_TRUNC_EN (per-node compare precision).
package dtree_pkg;

    localparam int NUM_FEAT   = 16;
    localparam int FEAT_W     = 8;
    localparam int CLS_W      = 4;
    localparam int MAX_DEPTH  = 16;
    localparam int FEAT_VEC_W = NUM_FEAT * FEAT_W;
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);
    localparam int FIDX_W     = $clog2(NUM_FEAT);
    localparam int PREC_W     = $clog2(FEAT_W + 1);

    localparam int NUM_NODES  = 5;
    // One spare code point so an out-of-range child is always representable.
    localparam int NODE_AW    = $clog2(NUM_NODES + 1);

    localparam logic [CLS_W-1:0] ERR_CLASS = {CLS_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic               is_leaf;
        logic [FIDX_W-1:0]  fidx;
        logic [FEAT_W-1:0]  thr;
`ifdef DTREE_PREC_TRUNC_EN
        logic [PREC_W-1:0]  prec;
`endif
        logic [NODE_AW-1:0] left;
        logic [NODE_AW-1:0] right;
        logic [CLS_W-1:0]   cls;
    } node_t;

`ifdef DTREE_PREC_TRUNC_EN
    localparam node_t NODES [NUM_NODES] = '{
        '{is_leaf: 1'b0, fidx: 4'd15, thr: 8'h1F, prec: 4'd2, left: 3'd1, right: 3'd2, cls: 4'd0},
        '{is_leaf: 1'b1, fidx: 4'd0,  thr: 8'h00, prec: 4'd8, left: 3'd0, right: 3'd0, cls: 4'd8},
        '{is_leaf: 1'b0, fidx: 4'd3,  thr: 8'h80, prec: 4'd8, left: 3'd3, right: 3'd4, cls: 4'd0},
        '{is_leaf: 1'b0, fidx: 4'd0,  thr: 8'hFF, prec: 4'd8, left: 3'd3, right: 3'd3, cls: 4'd0},
        '{is_leaf: 1'b1, fidx: 4'd0,  thr: 8'h00, prec: 4'd8, left: 3'd0, right: 3'd0, cls: 4'd9}
    };
`else
    localparam node_t NODES [NUM_NODES] = '{
        '{is_leaf: 1'b0, fidx: 4'd15, thr: 8'h1F, left: 3'd1, right: 3'd2, cls: 4'd0},
        '{is_leaf: 1'b1, fidx: 4'd0,  thr: 8'h00, left: 3'd0, right: 3'd0, cls: 4'd8},
        '{is_leaf: 1'b0, fidx: 4'd3,  thr: 8'h80, left: 3'd3, right: 3'd4, cls: 4'd0},
        '{is_leaf: 1'b0, fidx: 4'd0,  thr: 8'hFF, left: 3'd3, right: 3'd3, cls: 4'd0},
        '{is_leaf: 1'b1, fidx: 4'd0,  thr: 8'h00, left: 3'd0, right: 3'd0, cls: 4'd9}
    };
`endif

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node lookup; swap the table in dtree_pkg to retarget a dataset.
// Out-of-range addresses return an all-zero node (the FSM never issues them).
module dtree_node_rom
    import dtree_pkg::*;
(
    input  logic [NODE_AW-1:0] addr_i,
    output node_t              node_o
);

    // Address decode over the constant node table.
    always_comb begin
        node_o = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (addr_i == NODE_AW'(i)) begin
                node_o = NODES[i];
            end else begin
                node_o = node_o;
            end
        end
    end

endmodule

// File: rtl/dtree_seq_ctrl.sv
// Multi-cycle decision-tree evaluator: one node per clock through a shared comparator.
// Optional feature macro: DTREE_PREC_TRUNC_EN (compare only the top prec bits per node).
module dtree_seq_ctrl
    import dtree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FEAT_VEC_W-1:0] in_feat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CLS_W-1:0]      out_class,
    output logic [DEPTH_W-1:0]    out_depth,
    output logic                  out_err
);

    state_t                state_q, state_d;
    logic [FEAT_VEC_W-1:0] feat_q, feat_d;
    logic [NODE_AW-1:0]    addr_q, addr_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [CLS_W-1:0]      cls_q, cls_d;
    logic [DEPTH_W-1:0]    odepth_q, odepth_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;

    node_t                 node_s;
    logic [FEAT_W-1:0]     f_s;
    logic                  le_s;
    logic [NODE_AW-1:0]    child_s;

    dtree_node_rom u_rom (
        .addr_i (addr_q),
        .node_o (node_s)
    );

    // Shared comparator: selected feature against the current node threshold.
    always_comb begin
        f_s = feat_q[node_s.fidx*FEAT_W +: FEAT_W];
`ifdef DTREE_PREC_TRUNC_EN
        le_s = (f_s >> (PREC_W'(FEAT_W) - node_s.prec))
            <= (node_s.thr >> (PREC_W'(FEAT_W) - node_s.prec));
`else
        le_s = (f_s <= node_s.thr);
`endif
        child_s = le_s ? node_s.left : node_s.right;
    end

    // Next-state and result logic of the walk FSM.
    always_comb begin
        state_d  = state_q;
        feat_d   = feat_q;
        addr_d   = addr_q;
        depth_d  = depth_q;
        cls_d    = cls_q;
        odepth_d = odepth_q;
        err_d    = err_q;
        valid_d  = valid_q;
        in_ready = (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    addr_d  = '0;
                    depth_d = '0;
                    state_d = ST_WALK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (node_s.is_leaf) begin
                    cls_d    = node_s.cls;
                    odepth_d = depth_q;
                    err_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    cls_d    = ERR_CLASS;
                    odepth_d = DEPTH_W'(MAX_DEPTH);
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else if (child_s >= NODE_AW'(NUM_NODES)) begin
                    // Corrupt table entry: abort rather than read an undefined node.
                    cls_d    = ERR_CLASS;
                    odepth_d = depth_q;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    addr_d  = child_s;
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            feat_q   <= '0;
            addr_q   <= '0;
            depth_q  <= '0;
            cls_q    <= '0;
            odepth_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            feat_q   <= feat_d;
            addr_q   <= addr_d;
            depth_q  <= depth_d;
            cls_q    <= cls_d;
            odepth_q <= odepth_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_class = cls_q;
    assign out_depth = odepth_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_seq_ctrl.sv
// Directed bench for dtree_seq_ctrl: vector table plus backpressure and mid-walk reset sequences.
module tb_dtree_seq_ctrl;
    import dtree_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [FEAT_VEC_W-1:0] in_feat;
    logic                  out_valid;
    logic                  out_ready;
    logic [CLS_W-1:0]      out_class;
    logic [DEPTH_W-1:0]    out_depth;
    logic                  out_err;

    int tests = 0;
    int fails = 0;

    dtree_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_depth (out_depth),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f15;
        logic [7:0] f3;
        logic [3:0] cls;
        logic [4:0] depth;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FEAT_VEC_W-1:0] mkfeat(input logic [7:0] f15, input logic [7:0] f3);
        logic [FEAT_VEC_W-1:0] v;
        v = '0;
        v[15*8 +: 8] = f15;
        v[3*8 +: 8]  = f3;
        return v;
    endfunction

    function automatic logic [FEAT_VEC_W-1:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_vec(input logic [7:0] f15, input logic [7:0] f3);
        @(negedge clk);
        chk("in_ready_before_start", {31'd0, in_ready}, 32'd1);
        in_feat  = mkfeat(f15, f3);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_feat  = junk();
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic seen_valid;

        vecs[0] = '{f15: 8'h05, f3: 8'h00, cls: 4'd8, depth: 5'd1, err: 1'b0, lat: 2};
        vecs[1] = '{f15: 8'hF0, f3: 8'h90, cls: 4'd9, depth: 5'd2, err: 1'b0, lat: 3};
`ifdef DTREE_PREC_TRUNC_EN
        vecs[2] = '{f15: 8'h20, f3: 8'h90, cls: 4'd8, depth: 5'd1, err: 1'b0, lat: 2};
`else
        vecs[2] = '{f15: 8'h20, f3: 8'h90, cls: 4'd9, depth: 5'd2, err: 1'b0, lat: 3};
`endif
        vecs[3] = '{f15: 8'hF0, f3: 8'h10, cls: 4'hF, depth: 5'd16, err: 1'b1, lat: 17};

        // Reset with random stimulus on the inputs.
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_feat   = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_feat   = junk();
            @(negedge clk);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_class", {28'd0, out_class}, 32'd0);
            chk("rst_out_depth", {27'd0, out_depth}, 32'd0);
            chk("rst_out_err", {31'd0, out_err}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            start_vec(vecs[i].f15, vecs[i].f3);
            wait_valid(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_class", i), {28'd0, out_class}, {28'd0, vecs[i].cls});
            chk($sformatf("v%0d_depth", i), {27'd0, out_depth}, {27'd0, vecs[i].depth});
            chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].err});
            chk($sformatf("v%0d_in_ready_busy", i), {31'd0, in_ready}, 32'd0);
            release_result();
        end

        // Backpressure: hold DONE for 5 cycles while a new vector is offered.
        start_vec(8'hF0, 8'h90);
        wait_valid(lat);
        chk("bp_latency", lat, 3);
        @(negedge clk);
        in_valid = 1'b1;
        in_feat  = mkfeat(8'h05, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_class", {28'd0, out_class}, 32'd9);
            chk("bp_depth", {27'd0, out_depth}, 32'd2);
            chk("bp_err", {31'd0, out_err}, 32'd0);
        end
        in_valid = 1'b0;
        release_result();
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("bp_offer_not_captured", {31'd0, seen_valid}, 32'd0);
        chk("bp_idle_after", {31'd0, in_ready}, 32'd1);

        // Reset pulse in the middle of a long walk.
        start_vec(8'hF0, 8'h10);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_class", {28'd0, out_class}, 32'd0);
        chk("midrst_out_depth", {27'd0, out_depth}, 32'd0);
        chk("midrst_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("midrst_no_result", {31'd0, seen_valid}, 32'd0);
        chk("midrst_idle", {31'd0, in_ready}, 32'd1);

        // Normal operation resumes after the abort.
        start_vec(8'h05, 8'h00);
        wait_valid(lat);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_class", {28'd0, out_class}, 32'd8);
        chk("post_rst_depth", {27'd0, out_depth}, 32'd1);
        release_result();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
